// File: rtl/trig_sweep_pkg.sv
// Shared constants, FSM encodings and record layouts for the cos/sin LUT sweep sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package trig_sweep_pkg;

  localparam int PHASE_W         = 12;  // theta wraps modulo 2^PHASE_W
  localparam int DATA_W          = 16;  // signed LUT real/imag width
  localparam int CNT_W           = 13;  // wide enough for a full 4096-point sweep
  localparam int LUT_LAT_DEF     = 2;   // clocks from lut_theta to lut_real/lut_imag
  localparam int FIFO_DEPTH_DEF  = 4;   // result FIFO entries

  // FSM encodings kept as plain 2-bit constants for legacy tool compatibility
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Sideband travelling alongside a theta through the LUT pipeline
  typedef struct packed {
    logic               vld;
    logic [PHASE_W-1:0] theta;
    logic [CNT_W-1:0]   idx;
    logic               last;
  } tag_t;

  // One captured LUT result as stored in the result FIFO
  typedef struct packed {
    logic [PHASE_W-1:0]       theta;
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
    logic [CNT_W-1:0]         idx;
    logic                     last;
  } res_t;

  // Phase accumulation; the carry out of the top bit is intentionally dropped
  function automatic logic [PHASE_W-1:0] theta_add(input logic [PHASE_W-1:0] a,
                                                   input logic [PHASE_W-1:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/trig_result_fifo.sv
// Synchronous FIFO holding captured LUT results; head is presented combinationally.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: none internally; the caller guarantees no push to a full FIFO unless popping.
//
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_flush         empties the FIFO on the next edge (wins over push/pop)
//   i_push/i_push_dat  write one entry
//   i_pop           remove head entry (ignored when empty)
//   o_head_dat      current head entry
//   o_empty         no entries stored
//   o_count         number of stored entries
module trig_result_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [W-1:0]  i_push_dat,
  input  logic          i_pop,
  output logic [W-1:0]  o_head_dat,
  output logic          o_empty,
  output logic [AW:0]   o_count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_full;
  logic w_wr_en;
  logic w_rd_en;

  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  // A push at full is legal only when the head leaves in the same cycle
  assign w_wr_en = i_push && (!w_full || i_pop);
  assign w_rd_en = i_pop && !o_empty;
  assign o_head_dat = r_mem[r_rd_ptr];

  // Storage is reset so the head outputs read zero straight out of reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_en && !i_flush) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // The upstream credit scheme must make overflow impossible
  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_push && w_full && !i_pop && !i_flush));

endmodule

// File: rtl/trig_lut_sweep_ctrl.sv
// Sweeps a programmed phase range through the cos/sin LUT and streams captured results out.
// Latency: start sampled in cycle 0 -> lut_theta in cycle 1 -> res_valid in cycle LUT_LAT+2.
// Backpressure: res_ready low fills the result FIFO; issue stalls once results owed reach FIFO_DEPTH.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_start, i_abort        sweep request (IDLE only) / cancel with pipeline and FIFO flush
//   i_cfg_phase0/step/count sweep program, latched on an accepted start
//   o_busy, o_done          sweep in progress / one-cycle completion pulse
//   o_lut_theta             phase to the LUT core; i_lut_real/i_lut_imag return LUT_LAT clocks later
//   o_res_valid/i_res_ready result stream handshake
//   o_res_theta/real/imag/index/last  result fields (FIFO head)
module trig_lut_sweep_ctrl
  import trig_sweep_pkg::*;
#(
  parameter int LUT_LAT    = LUT_LAT_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_start,
  input  logic                      i_abort,
  input  logic [PHASE_W-1:0]        i_cfg_phase0,
  input  logic [PHASE_W-1:0]        i_cfg_step,
  input  logic [CNT_W-1:0]          i_cfg_count,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [PHASE_W-1:0]        o_lut_theta,
  input  logic signed [DATA_W-1:0]  i_lut_real,
  input  logic signed [DATA_W-1:0]  i_lut_imag,
  output logic                      o_res_valid,
  input  logic                      i_res_ready,
  output logic [PHASE_W-1:0]        o_res_theta,
  output logic signed [DATA_W-1:0]  o_res_real,
  output logic signed [DATA_W-1:0]  o_res_imag,
  output logic [CNT_W-1:0]          o_res_index,
  output logic                      o_res_last
);

  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW  = $clog2(FIFO_DEPTH + LUT_LAT + 1) + 1;

  state_t             r_state;
  logic [PHASE_W-1:0] r_phase_acc;   // next theta to issue
  logic [PHASE_W-1:0] r_step;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   r_issue_idx;   // index of next sample to issue
  logic [PHASE_W-1:0] r_lut_theta;
  // Stage 0 sits beside r_lut_theta; stage LUT_LAT lines up with the LUT data
  tag_t               r_tag [0:LUT_LAT];

  logic               w_accept;
  logic               w_flush;
  logic               w_pop;
  logic               w_last_hs;
  logic               w_credit_ok;
  logic               w_issue_run;
  logic               w_push;
  tag_t               w_issue_tag;
  res_t               w_push_dat;
  res_t               w_head;
  logic               w_empty;
  logic [FCW-1:0]     w_fifo_cnt;
  logic [CW-1:0]      w_inflight;
  logic [CW-1:0]      w_owed;

  // abort beats start: a start with abort in the same cycle is dropped
  assign w_accept  = (r_state == ST_IDLE) && i_start && !i_abort;
  assign w_flush   = i_abort && ((r_state == ST_ISSUE) || (r_state == ST_DRAIN));
  assign w_pop     = o_res_valid && i_res_ready;
  assign w_last_hs = w_pop && w_head.last;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i <= LUT_LAT; i++) w_inflight = w_inflight + CW'(r_tag[i].vld);
  end

  // Results owed FIFO space: stored entries not leaving this cycle plus everything in the
  // LUT pipe. Counting this cycle's pop keeps one issue per clock with res_ready high.
  assign w_owed      = CW'(w_fifo_cnt) - CW'(w_pop) + w_inflight;
  assign w_credit_ok = (w_owed < CW'(FIFO_DEPTH));
  assign w_issue_run = (r_state == ST_ISSUE) && !i_abort && w_credit_ok;

  // The first sample goes out on the accepting edge, so lut_theta = phase0 in cycle 1
  always_comb begin
    w_issue_tag = '0;
    if (w_accept && (i_cfg_count != '0)) begin
      w_issue_tag.vld   = 1'b1;
      w_issue_tag.theta = i_cfg_phase0;
      w_issue_tag.idx   = '0;
      w_issue_tag.last  = (i_cfg_count == CNT_W'(1));
    end else if (w_issue_run) begin
      w_issue_tag.vld   = 1'b1;
      w_issue_tag.theta = r_phase_acc;
      w_issue_tag.idx   = r_issue_idx;
      w_issue_tag.last  = (r_issue_idx == (r_count - CNT_W'(1)));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_phase_acc <= '0;
      r_step      <= '0;
      r_count     <= '0;
      r_issue_idx <= '0;
      r_lut_theta <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_step  <= i_cfg_step;
            r_count <= i_cfg_count;
            if (i_cfg_count == '0) begin
              r_state <= ST_DONE;
            end else begin
              r_lut_theta <= i_cfg_phase0;
              r_phase_acc <= theta_add(i_cfg_phase0, i_cfg_step);
              r_issue_idx <= CNT_W'(1);
              r_state     <= (i_cfg_count == CNT_W'(1)) ? ST_DRAIN : ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (i_abort) begin
            r_state     <= ST_IDLE;
            r_lut_theta <= '0;
          end else if (w_issue_run) begin
            r_lut_theta <= r_phase_acc;
            r_phase_acc <= theta_add(r_phase_acc, r_step);
            r_issue_idx <= r_issue_idx + CNT_W'(1);
            if (w_issue_tag.last) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (i_abort) begin
            r_state     <= ST_IDLE;
            r_lut_theta <= '0;
          end else if (w_last_hs) begin
            r_state     <= ST_DONE;
            r_lut_theta <= '0;
          end
        end
        ST_DONE: begin
          r_state     <= ST_IDLE;
          r_lut_theta <= '0;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_lut_theta <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i <= LUT_LAT; i++) r_tag[i] <= '0;
    end else if (w_flush) begin
      for (int i = 0; i <= LUT_LAT; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= w_issue_tag;
      for (int i = 1; i <= LUT_LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  assign w_push           = r_tag[LUT_LAT].vld;
  assign w_push_dat.theta = r_tag[LUT_LAT].theta;
  assign w_push_dat.re    = i_lut_real;
  assign w_push_dat.im    = i_lut_imag;
  assign w_push_dat.idx   = r_tag[LUT_LAT].idx;
  assign w_push_dat.last  = r_tag[LUT_LAT].last;

  trig_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(res_t))
  ) u_fifo (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_flush    (w_flush),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_empty    (w_empty),
    .o_count    (w_fifo_cnt)
  );

  assign o_busy      = (r_state == ST_ISSUE) || (r_state == ST_DRAIN);
  assign o_done      = (r_state == ST_DONE);
  assign o_lut_theta = r_lut_theta;
  assign o_res_valid = !w_empty;
  assign o_res_theta = w_head.theta;
  assign o_res_real  = w_head.re;
  assign o_res_imag  = w_head.im;
  assign o_res_index = w_head.idx;
  assign o_res_last  = w_head.last;

endmodule

// File: tb/tb_trig_lut_sweep_ctrl.sv
module tb_trig_lut_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [11:0] cfg_phase0 = '0;
  logic [11:0] cfg_step = '0;
  logic [12:0] cfg_count = '0;
  logic        busy, done, res_valid, res_last;
  logic        res_ready = 1'b1;
  logic [11:0] lut_theta, res_theta;
  logic [15:0] lut_real, lut_imag, res_real, res_imag;
  logic [12:0] res_index;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  trig_lut_sweep_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_cfg_phase0(cfg_phase0), .i_cfg_step(cfg_step), .i_cfg_count(cfg_count),
    .o_busy(busy), .o_done(done), .o_lut_theta(lut_theta),
    .i_lut_real(lut_real), .i_lut_imag(lut_imag),
    .o_res_valid(res_valid), .i_res_ready(res_ready),
    .o_res_theta(res_theta), .o_res_real(res_real), .o_res_imag(res_imag),
    .o_res_index(res_index), .o_res_last(res_last)
  );

  // LUT core model: two-clock latency, distinct values per theta
  function automatic logic [15:0] f_re(input logic [11:0] t);
    return {t, 4'h3} ^ 16'hA5A5;
  endfunction
  function automatic logic [15:0] f_im(input logic [11:0] t);
    return {~t, t[3:0]};
  endfunction

  logic [11:0] lut_p1 = '0, lut_p2 = '0;
  always @(posedge clk) begin
    lut_p1 <= lut_theta;
    lut_p2 <= lut_p1;
  end
  assign lut_real = f_re(lut_p2);
  assign lut_imag = f_im(lut_p2);

  typedef struct packed {
    logic [11:0] th;
    logic [15:0] re;
    logic [15:0] im;
    logic [12:0] idx;
    logic        last;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Cycle k = the clock period in which start is high for k==0. Outputs sampled and inputs
  // driven at the falling edge of each cycle.
  task automatic run_sweep(input logic [11:0] p0, input logic [11:0] st, input logic [12:0] cnt,
                           input int lo, input int hi, input int abort_idx, input int budget,
                           output int nres, output int done_cyc, output int ndone,
                           output int nbusy, output int nvld, output logic [11:0] last_th,
                           output logic [11:0] th20, output int post_abort);
    int ka;
    exp_t e, a;
    nres = 0; done_cyc = -1; ndone = 0; nbusy = 0; nvld = 0;
    last_th = '0; th20 = '0; post_abort = -1; ka = -1;
    sb.delete();
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (res_valid) nvld++;
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (k == 20) th20 = lut_theta;
      if (ka >= 0 && k == ka + 1)
        post_abort = {29'd0, res_valid, busy, (lut_theta != 12'd0)};
      start      = (k == 0);
      cfg_phase0 = p0;
      cfg_step   = st;
      cfg_count  = cnt;
      res_ready  = !(k >= lo && k <= hi);
      abort      = (abort_idx >= 0) && (ka < 0) && res_valid && (res_index == 13'(abort_idx));
      if (k == 0) begin
        for (int i = 0; i < int'(cnt); i++) begin
          e.th   = p0 + st * 12'(i);
          e.re   = f_re(e.th);
          e.im   = f_im(e.th);
          e.idx  = 13'(i);
          e.last = (i == int'(cnt) - 1);
          sb.push_back(e);
        end
      end
      if (abort) begin
        ka = k;
        sb.delete();
      end else if (res_valid && res_ready) begin
        nres++;
        last_th = res_theta;
        a = {res_theta, res_real, res_imag, res_index, res_last};
        if (sb.size() == 0) begin
          chk("unexpected_result", 64'(a), 64'd0);
        end else begin
          e = sb.pop_front();
          chk($sformatf("result_idx%0d", e.idx), 64'(a), 64'(e));
        end
      end
      if (done_cyc >= 0 && k >= done_cyc + 3) break;
      if (ka >= 0 && k >= ka + 12) break;
    end
    start = 1'b0;
    abort = 1'b0;
    res_ready = 1'b1;
    if (abort_idx < 0) chk("missing_results", 64'(sb.size()), 64'd0);
  endtask

  typedef struct {
    logic [11:0] p0;
    logic [11:0] st;
    logic [12:0] cnt;
    int          lo;
    int          hi;
    int          exp_n;
    int          exp_done;
    logic [11:0] exp_last;
    logic [11:0] exp_hold;
  } vec_t;

  vec_t vecs[5];
  int nres, done_cyc, ndone, nbusy, nvld, post_abort;
  logic [11:0] last_th, th20;

  initial begin
    vecs[0] = '{12'h000, 12'h001, 13'd4096, -1, -1, 4096, 4100, 12'hFFF, 12'h000};
    vecs[1] = '{12'hFFE, 12'h003, 13'd4,    -1, -1, 4,    8,    12'h007, 12'h000};
    vecs[2] = '{12'h123, 12'h010, 13'd10,    3, 22, 10,   33,   12'h1B3, 12'h153};
    vecs[3] = '{12'h7FF, 12'h800, 13'd3,    -1, -1, 3,    7,    12'h7FF, 12'h000};
    vecs[4] = '{12'hABC, 12'h005, 13'd1,    -1, -1, 1,    5,    12'hABC, 12'h000};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_lut_theta", 64'(lut_theta), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_last", 64'(res_last), 64'd0);
    chk("rst_res_theta", 64'(res_theta), 64'd0);
    chk("rst_res_real", 64'(res_real), 64'd0);
    chk("rst_res_imag", 64'(res_imag), 64'd0);
    chk("rst_res_index", 64'(res_index), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven sweeps
    for (int v = 0; v < 5; v++) begin
      run_sweep(vecs[v].p0, vecs[v].st, vecs[v].cnt, vecs[v].lo, vecs[v].hi, -1,
                vecs[v].exp_done + 40, nres, done_cyc, ndone, nbusy, nvld, last_th, th20, post_abort);
      chk($sformatf("v%0d_nres", v), 64'(nres), 64'(vecs[v].exp_n));
      chk($sformatf("v%0d_done_cycle", v), 64'(done_cyc), 64'(vecs[v].exp_done));
      chk($sformatf("v%0d_done_pulses", v), 64'(ndone), 64'd1);
      chk($sformatf("v%0d_last_theta", v), 64'(last_th), 64'(vecs[v].exp_last));
      if (vecs[v].lo >= 0) chk($sformatf("v%0d_stall_theta", v), 64'(th20), 64'(vecs[v].exp_hold));
      chk($sformatf("v%0d_idle_busy", v), 64'(busy), 64'd0);
    end

    // count == 0: immediate done, never busy, never valid
    run_sweep(12'h005, 12'h001, 13'd0, -1, -1, -1, 20,
              nres, done_cyc, ndone, nbusy, nvld, last_th, th20, post_abort);
    chk("zero_done_cycle", 64'(done_cyc), 64'd1);
    chk("zero_done_pulses", 64'(ndone), 64'd1);
    chk("zero_busy_cycles", 64'(nbusy), 64'd0);
    chk("zero_valid_cycles", 64'(nvld), 64'd0);

    // abort while index 5 is at the head of a 100-sample sweep
    run_sweep(12'h100, 12'h002, 13'd100, -1, -1, 5, 200,
              nres, done_cyc, ndone, nbusy, nvld, last_th, th20, post_abort);
    chk("abort_post_state", 64'(post_abort), 64'd0);
    chk("abort_nres", 64'(nres), 64'd5);
    chk("abort_no_done", 64'(ndone), 64'd0);
    run_sweep(12'h200, 12'h001, 13'd3, -1, -1, -1, 60,
              nres, done_cyc, ndone, nbusy, nvld, last_th, th20, post_abort);
    chk("post_abort_nres", 64'(nres), 64'd3);
    chk("post_abort_done_cycle", 64'(done_cyc), 64'd7);
    chk("post_abort_last_theta", 64'(last_th), 64'h202);

    // reset mid-sweep with results parked in the FIFO
    @(negedge clk);
    cfg_phase0 = 12'h300; cfg_step = 12'h001; cfg_count = 13'd50;
    res_ready = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("prereset_valid", 64'(res_valid), 64'd1);
    chk("prereset_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_valid", 64'(res_valid), 64'd0);
    chk("midreset_busy", 64'(busy), 64'd0);
    chk("midreset_lut_theta", 64'(lut_theta), 64'd0);
    rst_n = 1'b1;
    res_ready = 1'b1;
    run_sweep(12'h400, 12'h001, 13'd2, -1, -1, -1, 60,
              nres, done_cyc, ndone, nbusy, nvld, last_th, th20, post_abort);
    chk("postreset_nres", 64'(nres), 64'd2);
    chk("postreset_done_cycle", 64'(done_cyc), 64'd6);
    chk("postreset_last_theta", 64'(last_th), 64'h401);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
